mips_instr_encoder: RTL and testbench

//  Encoder/loader for the single-cycle MIPS instruction memory. It accepts decoded

---
 rtl/mips_instr_encoder.sv | 141 ++++++++++++++
 tb/tb_mips_instr_encoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//   Loads the single-cycle MIPS instruction memory from a stream of decoded
//   mnemonic commands. Each accepted legal command is packed into a 32-bit
//   MIPS word and written to the next sequential word address one cycle later.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start                     opens a load session (honoured in IDLE/DONE)
//   cmd_valid / cmd_ready     command handshake; ready is high only in LOAD
//   cmd_op, cmd_rs, cmd_rt,   mnemonic (0..8 legal) and operand fields
//   cmd_rd, cmd_imm, cmd_last
//   imem_we/addr/wdata        instruction memory write port
//   busy, done                session state flags (LOAD / DONE)
//   err_illegal, err_full     one-cycle pulses for dropped commands
//   word_count                words written in the current session
module mips_instr_encoder #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_op,
    input  logic [4:0]                 cmd_rs,
    input  logic [4:0]                 cmd_rt,
    input  logic [4:0]                 cmd_rd,
    input  logic [15:0]                cmd_imm,
    input  logic                       cmd_last,
    output logic                       imem_we,
    output logic [31:0]                imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       err_illegal,
    output logic                       err_full,
    output logic [$clog2(DEPTH):0]     word_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state;
    logic          we_p1;
    logic [31:0]   addr_p1;
    logic [31:0]   wdata_p1;
    logic [32:0]   enc_p0;
    logic          accept_p0;

    // Returns {legal, word}; the word is meaningless when legal is 0.
    function automatic logic [32:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [5:0] funct;
        logic [5:0] opcode;
        logic       legal;
        logic       rtype;
        funct  = 6'b000000;
        opcode = 6'b000000;
        legal  = 1'b1;
        rtype  = 1'b1;
        case (op)
            4'd0: funct = 6'b100000;
            4'd1: funct = 6'b100010;
            4'd2: funct = 6'b100100;
            4'd3: funct = 6'b100101;
            4'd4: funct = 6'b101010;
            4'd5: begin rtype = 1'b0; opcode = 6'b100011; end
            4'd6: begin rtype = 1'b0; opcode = 6'b101011; end
            4'd7: begin rtype = 1'b0; opcode = 6'b000100; end
            4'd8: begin rtype = 1'b0; opcode = 6'b001000; end
            default: legal = 1'b0;
        endcase
        if (rtype)
            return {legal, 6'b000000, rs, rt, rd, 5'b00000, funct};
        else
            return {legal, opcode, rs, rt, imm};
    endfunction

    assign cmd_ready = (state == LOAD);
    assign busy      = (state == LOAD);
    assign done      = (state == DONE);

    // p0: command accepted and encoded
    assign accept_p0 = cmd_valid & cmd_ready;
    assign enc_p0    = encode(cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word_count  <= '0;
            we_p1       <= 1'b0;
            addr_p1     <= '0;
            wdata_p1    <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            we_p1       <= 1'b0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        word_count <= '0;
                    end
                end
                LOAD: begin
                    if (accept_p0) begin
                        if (!enc_p0[32]) begin
                            err_illegal <= 1'b1;
                        end else if (word_count == FULL) begin
                            err_full <= 1'b1;
                        end else begin
                            we_p1      <= 1'b1;
                            addr_p1    <= BASE_ADDR + (32'(word_count) << 2);
                            wdata_p1   <= enc_p0[31:0];
                            word_count <= word_count + 1'b1;
                        end
                        if (cmd_last)
                            state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p1: write port; a reset in the issue cycle kills the pending write
    assign imem_we    = we_p1 & ~rst;
    assign imem_addr  = addr_p1;
    assign imem_wdata = wdata_p1;

endmodule

// File: tb/tb_mips_instr_encoder.sv
module tb_mips_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_op = '0;
    logic [4:0]    cmd_rs = '0;
    logic [4:0]    cmd_rt = '0;
    logic [4:0]    cmd_rd = '0;
    logic [15:0]   cmd_imm = '0;
    logic          cmd_last = 1'b0;
    logic          imem_we;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err_illegal;
    logic          err_full;
    logic [CW-1:0] word_count;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    mips_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm), .cmd_last(cmd_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err_illegal(err_illegal), .err_full(err_full),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: instruction word built from the MIPS field layout by arithmetic.
    function automatic logic [31:0] model_word(int op, int rs, int rt, int rd, int imm);
        int funct_of[5] = '{32, 34, 36, 37, 42};
        int opc_of[4]   = '{35, 43, 4, 8};
        longint w;
        if (op < 5)
            w = longint'(rs) * (1 << 21) + longint'(rt) * (1 << 16) + longint'(rd) * (1 << 11) + funct_of[op];
        else
            w = longint'(opc_of[op-5]) * (longint'(1) << 26) + longint'(rs) * (1 << 21)
                + longint'(rt) * (1 << 16) + imm;
        return w[31:0];
    endfunction

    // Session-level model: 0 idle, 1 loading, 2 finished.
    int          m_st = 0;
    int          m_cnt = 0;
    bit          m_we = 0, m_eil = 0, m_efu = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_st = 0; m_cnt = 0; m_we = 0; m_eil = 0; m_efu = 0;
            m_addr = '0; m_wdata = '0;
        end else begin
            m_we = 0; m_eil = 0; m_efu = 0;
            if (m_st == 1) begin
                if (cmd_valid) begin
                    if (cmd_op > 8) m_eil = 1;
                    else if (m_cnt == DEPTH) m_efu = 1;
                    else begin
                        m_we    = 1;
                        m_addr  = BASE + 32'(4 * m_cnt);
                        m_wdata = model_word(int'(cmd_op), int'(cmd_rs), int'(cmd_rt),
                                             int'(cmd_rd), int'(cmd_imm));
                        m_cnt++;
                    end
                    if (cmd_last) m_st = 2;
                end
            end else if (start) begin
                m_st = 1; m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(m_st == 1));
            chk("busy", 32'(busy), 32'(m_st == 1));
            chk("done", 32'(done), 32'(m_st == 2));
            chk("imem_we", 32'(imem_we), 32'(m_we && !rst));
            chk("imem_addr", imem_addr, m_addr);
            chk("imem_wdata", imem_wdata, m_wdata);
            chk("err_illegal", 32'(err_illegal), 32'(m_eil));
            chk("err_full", 32'(err_full), 32'(m_efu));
            chk("word_count", 32'(word_count), 32'(m_cnt));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1; tick; start = 1'b0;
    endtask

    task automatic drive(input int op, input int rs, input int rt, input int rd,
                         input int imm, input bit last);
        cmd_valid = 1'b1;
        cmd_op = 4'(op); cmd_rs = 5'(rs); cmd_rt = 5'(rt); cmd_rd = 5'(rd);
        cmd_imm = 16'(imm); cmd_last = last;
        tick;
        cmd_valid = 1'b0; cmd_last = 1'b0;
    endtask

    initial begin
        do_reset;
        chk_en = 1'b1;
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", 32'(word_count), 0);

        // 1: single ADD
        pulse_start;
        drive(0, 1, 2, 3, 0, 0);
        chk("t1_we", 32'(imem_we), 1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_wdata", imem_wdata, 32'h00221820);
        chk("t1_count", 32'(word_count), 1);

        // 2: back-to-back LW, SW, BEQ(last)
        do_reset;
        pulse_start;
        drive(5, 0, 8, 0, 4, 0);
        chk("t2_lw", imem_wdata, 32'h8C080004);
        chk("t2_lw_addr", imem_addr, 32'h0);
        drive(6, 29, 4, 0, 8, 0);
        chk("t2_sw", imem_wdata, 32'hAFA40008);
        chk("t2_sw_addr", imem_addr, 32'h4);
        drive(7, 1, 2, 0, 16'hFFFF, 1);
        chk("t2_beq", imem_wdata, 32'h1022FFFF);
        chk("t2_beq_addr", imem_addr, 32'h8);
        chk("t2_beq_we", 32'(imem_we), 1);
        chk("t2_done", 32'(done), 1);
        chk("t2_count", 32'(word_count), 3);

        // 3: illegal op then ADDI (restart from DONE)
        pulse_start;
        drive(12, 3, 3, 3, 3, 0);
        chk("t3_eil", 32'(err_illegal), 1);
        chk("t3_eil_we", 32'(imem_we), 0);
        chk("t3_eil_count", 32'(word_count), 0);
        drive(8, 0, 5, 0, 16'h0010, 0);
        chk("t3_addi", imem_wdata, 32'h20050010);
        chk("t3_addi_addr", imem_addr, 32'h0);
        chk("t3_eil_clr", 32'(err_illegal), 0);

        // 4: overflow with DEPTH=4
        do_reset;
        pulse_start;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 2, 3, 0, i == 4);
            if (i < 4) begin
                chk("t4_we", 32'(imem_we), 1);
                chk("t4_addr", imem_addr, 32'(4 * i));
            end
        end
        chk("t4_full_we", 32'(imem_we), 0);
        chk("t4_efu", 32'(err_full), 1);
        chk("t4_done", 32'(done), 1);
        chk("t4_count", 32'(word_count), 4);
        tick;
        chk("t4_efu_pulse", 32'(err_full), 0);

        // 5: reset right after an accept kills the write
        do_reset;
        pulse_start;
        drive(0, 1, 2, 3, 0, 0);
        rst = 1'b1;
        #1;
        chk("t5_we_killed", 32'(imem_we), 0);
        tick;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_count", 32'(word_count), 0);
        chk("t5_wdata", imem_wdata, 0);
        rst = 1'b0;
        pulse_start;
        drive(0, 1, 2, 3, 0, 0);
        chk("t5_restart_addr", imem_addr, BASE);
        chk("t5_restart_we", 32'(imem_we), 1);

        // 6: ignored start and commands outside LOAD
        do_reset;
        cmd_valid = 1'b1; cmd_op = 4'd0;
        tick; tick;
        chk("t6_idle_ready", 32'(cmd_ready), 0);
        chk("t6_idle_we", 32'(imem_we), 0);
        cmd_valid = 1'b0;
        pulse_start;
        drive(0, 1, 2, 3, 0, 0);
        start = 1'b1;
        drive(0, 4, 5, 6, 0, 1);
        start = 1'b0;
        chk("t6_start_in_load", 32'(word_count), 2);
        chk("t6_addr2", imem_addr, 32'h4);
        cmd_valid = 1'b1;
        tick; tick;
        chk("t6_done_ready", 32'(cmd_ready), 0);
        chk("t6_done_we", 32'(imem_we), 0);
        cmd_valid = 1'b0;

        // Random traffic against the model
        do_reset;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(63) == 0);
            start     = ($urandom_range(7) == 0);
            cmd_valid = ($urandom_range(3) != 0);
            cmd_op    = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(8));
            cmd_rs    = 5'($urandom);
            cmd_rt    = 5'($urandom);
            cmd_rd    = 5'($urandom);
            cmd_imm   = 16'($urandom);
            cmd_last  = ($urandom_range(7) == 0);
            tick;
        end
        rst = 1'b0; start = 1'b0; cmd_valid = 1'b0;
        tick;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
